// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the multi-cycle core:
//                pipeline stage numbers, fetch FSM states, NOP encoding and
//                fetch fault cause codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Controller stage numbering
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;

  // Fetch stage states
  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_FAULT = 2'd2
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fault cause codes
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_PROTO    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
//  Module      : pc_reg
//  Description : Program counter register with pc+4 adder, branch target
//                select and target alignment check. A misaligned taken
//                branch leaves the PC untouched.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update_i,         // commit accepted this cycle
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] pc_next_o,        // PC as seen after this cycle's commit
  output logic        misalign_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;
  assign misalign_o = branch_taken_i && (branch_target_i[1:0] != 2'b00);

  // Without a commit the next PC is the current one, so a same-cycle fetch
  // always addresses the post-commit PC.
  assign pc_next_o = !update_i      ? pc_q            :
                     branch_taken_i ? branch_target_i : pc_plus4_o;

  assign pc_d = (update_i && !misalign_o) ? pc_next_o : pc_q;

  // PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, issues one
//                instruction memory request per fetch_start over a
//                req/ready handshake and holds the word for decode.
//                Misaligned targets, memory timeouts and commands arriving
//                mid-request raise a sticky fault.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255,           // 1..255
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic        pc_update,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_raw,
  output logic        fetch_done,
  output logic        fetch_busy,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  // Last wait count value before the request is declared lost
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  fetch_state_t state_q;
  logic         imem_req_q;
  logic [31:0]  imem_addr_q;
  logic [31:0]  instr_q;
  logic         fetch_done_q;
  logic [7:0]   wait_q;
  logic         fault_q;
  logic [1:0]   fault_cause_q;

  logic         w_pc_upd;
  logic [31:0]  w_pc_next;
  logic         w_misalign;
  logic         w_err_misalign;
  logic         w_err_proto;
  logic         w_err_timeout;

  // PC commits are honoured only while idle
  assign w_pc_upd = pc_update && (state_q == FS_IDLE);

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .rst             (rst),
    .update_i        (w_pc_upd),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .pc_o            (pc),
    .pc_plus4_o      (pc_plus4),
    .pc_next_o       (w_pc_next),
    .misalign_o      (w_misalign)
  );

  assign w_err_misalign = w_pc_upd && w_misalign;
  assign w_err_proto    = (state_q == FS_REQ) && (pc_update || fetch_start);
  assign w_err_timeout  = (state_q == FS_REQ) && !imem_ready && (wait_q == WAIT_LAST);

  // Sticky fault flag; the first recorded cause is kept until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q       <= 1'b0;
      fault_cause_q <= FC_NONE;
    end else if (!fault_q) begin
      if (w_err_misalign) begin
        fault_q       <= 1'b1;
        fault_cause_q <= FC_MISALIGN;
      end else if (w_err_proto) begin
        fault_q       <= 1'b1;
        fault_cause_q <= FC_PROTO;
      end else if (w_err_timeout) begin
        fault_q       <= 1'b1;
        fault_cause_q <= FC_TIMEOUT;
      end
    end
  end

  // Fetch FSM with registered request, address, instruction and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FS_IDLE;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      instr_q      <= NOP;
      fetch_done_q <= 1'b0;
      wait_q       <= 8'd0;
    end else begin
      fetch_done_q <= 1'b0;
      case (state_q)
        FS_IDLE: begin
          if (w_err_misalign) begin
            state_q <= FS_FAULT;
          end else if (fetch_start && !fault_q) begin
            imem_addr_q <= w_pc_next;
            imem_req_q  <= 1'b1;
            wait_q      <= 8'd0;
            state_q     <= FS_REQ;
          end
        end
        FS_REQ: begin
          if (imem_ready) begin
            // A protocol error lets the outstanding transfer finish first
            instr_q      <= imem_rdata;
            imem_req_q   <= 1'b0;
            fetch_done_q <= 1'b1;
            state_q      <= (fault_q || w_err_proto) ? FS_FAULT : FS_IDLE;
          end else if (w_err_timeout) begin
            imem_req_q <= 1'b0;
            state_q    <= FS_FAULT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        FS_FAULT: begin
          imem_req_q <= 1'b0;
        end
        default: begin
          imem_req_q <= 1'b0;
          state_q    <= FS_FAULT;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_raw   = instr_q;
  assign fetch_done  = fetch_done_q;
  assign fetch_busy  = (state_q == FS_REQ);
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed scenarios plus
//                randomized episodes compared against a transaction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 255;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic        pc_update;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_raw;
  logic        fetch_done;
  logic        fetch_busy;
  logic        fault;
  logic [1:0]  fault_cause;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic [31:0] m_instr;
  bit          m_busy;
  bit          m_done;
  bit          m_fault;
  bit          m_halt;
  logic [1:0]  m_cause;
  int          m_waited;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT),
    .NOP      (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_start   (fetch_start),
    .pc_update     (pc_update),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_raw     (instr_raw),
    .fetch_done    (fetch_done),
    .fetch_busy    (fetch_busy),
    .fault         (fault),
    .fault_cause   (fault_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc     = RESET_PC;
    m_addr   = RESET_PC;
    m_instr  = NOP;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_fault  = 1'b0;
    m_halt   = 1'b0;
    m_cause  = 2'b00;
    m_waited = 0;
  endfunction

  function automatic void raise(input logic [1:0] c);
    if (!m_fault) begin
      m_fault = 1'b1;
      m_cause = c;
    end
  endfunction

  // One clock of the fetch stage, written as transactions: idle commands,
  // an outstanding request, or a halted stage.
  function automatic void model_step(input logic fs, input logic pu, input logic bt,
                                     input logic [31:0] tgt, input logic rdy,
                                     input logic [31:0] rd);
    logic [31:0] nxt;
    m_done = 1'b0;
    if (m_halt) begin
      // nothing moves until reset
    end else if (!m_busy) begin
      if (pu) begin
        nxt = bt ? tgt : m_pc + 32'd4;
        if (bt && (tgt % 4 != 0)) begin
          raise(2'b01);
          m_halt = 1'b1;
        end else begin
          m_pc = nxt;
        end
      end
      if (!m_halt && fs) begin
        m_busy   = 1'b1;
        m_addr   = m_pc;
        m_waited = 0;
      end
    end else begin
      if (pu || fs) raise(2'b11);
      if (rdy) begin
        m_instr = rd;
        m_busy  = 1'b0;
        m_done  = 1'b1;
        if (m_fault) m_halt = 1'b1;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) begin
          raise(2'b10);
          m_busy = 1'b0;
          m_halt = 1'b1;
        end
      end
    end
  endfunction

  task automatic check_model();
    check("pc",          pc,                 m_pc);
    check("pc_plus4",    pc_plus4,           m_pc + 32'd4);
    check("imem_req",    32'(imem_req),      32'(m_busy));
    check("imem_addr",   imem_addr,          m_addr);
    check("instr_raw",   instr_raw,          m_instr);
    check("fetch_done",  32'(fetch_done),    32'(m_done));
    check("fetch_busy",  32'(fetch_busy),    32'(m_busy));
    check("fault",       32'(fault),         32'(m_fault));
    check("fault_cause", 32'(fault_cause),   32'(m_cause));
  endtask

  // Drive one cycle of inputs (from a negedge), clock it, compare at the next negedge
  task automatic step(input logic r, input logic fs, input logic pu, input logic bt,
                      input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
    rst           = r;
    fetch_start   = fs;
    pc_update     = pu;
    branch_taken  = bt;
    branch_target = tgt;
    imem_ready    = rdy;
    imem_rdata    = rd;
    @(posedge clk);
    if (r) model_reset();
    else   model_step(fs, pu, bt, tgt, rdy, rd);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] tgt;
    model_reset();

    // Reset state
    do_reset();
    check("rst_pc",    pc,                 32'h0);
    check("rst_instr", instr_raw,          32'h0000_0013);
    check("rst_fault", 32'(fault),         32'h0);
    check("rst_req",   32'(imem_req),      32'h0);

    // Minimum-latency fetch
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("f1_req",  32'(imem_req), 32'h1);
    check("f1_addr", imem_addr,     32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0093);
    check("f1_done",  32'(fetch_done), 32'h1);
    check("f1_instr", instr_raw,       32'h0050_0093);
    idle();
    check("f1_done_pulse", 32'(fetch_done), 32'h0);

    // Sequential commit and wrap
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("pc_seq", pc, 32'h14);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    check("pc_wrap", pc_plus4, 32'h0);

    // Commit and fetch in the same cycle
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    check("cf_addr", imem_addr, 32'h40);
    check("cf_pc",   pc,        32'h40);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);

    // Misaligned branch target
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h42, 1'b0, 32'h0);
    check("mis_fault", 32'(fault),       32'h1);
    check("mis_cause", 32'(fault_cause), 32'h1);
    check("mis_pc",    pc,               32'h40);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("mis_noreq", 32'(imem_req), 32'h0);

    // Memory timeout
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0093);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < TIMEOUT - 1; i++) idle();
    check("to_early_fault", 32'(fault),    32'h0);
    check("to_early_req",   32'(imem_req), 32'h1);
    idle();
    check("to_fault", 32'(fault),       32'h1);
    check("to_cause", 32'(fault_cause), 32'h2);
    check("to_req",   32'(imem_req),    32'h0);
    check("to_instr", instr_raw,        32'hCAFE_0093);

    // Reset during an outstanding request, then a late ready
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("rr_req",   32'(imem_req), 32'h0);
    check("rr_instr", instr_raw,     32'h0000_0013);
    check("rr_pc",    pc,            32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    check("rr_late_instr", instr_raw,       32'h0000_0013);
    check("rr_late_done",  32'(fetch_done), 32'h0);

    // Randomized episodes
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      for (int c = 0; c < 40; c++) begin
        tgt = $urandom;
        if ($urandom_range(9) != 0) tgt[1:0] = 2'b00;
        step(1'b0,
             1'($urandom_range(9) < 3),
             1'($urandom_range(9) < 2),
             1'($urandom_range(1)),
             tgt,
             1'($urandom_range(9) < 6),
             $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
